// File: rtl/imem_loader_if.sv
// Program-load word stream between a boot source (master) and the instruction
// memory loader (slave): one 32-bit word per valid/ready handshake.
interface imem_loader_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;

  modport master (output load_valid, output load_data, output load_last, input  load_ready);
  modport slave  (input  load_valid, input  load_data, input  load_last, output load_ready);
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with a streaming program loader and CPU reset sequencer.
// Holds the CPU in reset while loading, releases it after a delay, then serves fetches.
module imem_loader #(
  parameter int unsigned DEPTH         = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN      = 32'h0000_0013,
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  imem_loader_if.slave             load,
  input  logic                     reload,
  input  logic [31:0]              pc,
  output logic [31:0]              instruction,
  output logic                     cpu_rst_n,
  output logic [$clog2(DEPTH):0]   loaded_words,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RELEASE_DELAY + 2);

  typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [AW:0]   words_next;
  logic          accept;
  logic [31:0]   mem [DEPTH];

  logic [31:0]   off;
  logic [29:0]   idx;
  logic          unused_off_lsbs;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_next      = state;
    cnt_next        = cnt;
    words_next      = loaded_words;
    accept          = 1'b0;
    load.load_ready = 1'b0;
    busy            = 1'b1;

    case (state)
      LOAD: begin
        load.load_ready = 1'b1;
        accept          = load.load_valid;
        if (accept) begin
          words_next = loaded_words + 1'b1;
          // The word that fills the last slot ends the load even without load_last.
          if (load.load_last || loaded_words == (AW+1)'(DEPTH - 1)) begin
            state_next = HOLD;
            cnt_next   = CW'(RELEASE_DELAY);
          end
        end
      end
      HOLD: begin
        if (cnt == '0) state_next = RUN;
        else           cnt_next   = cnt - 1'b1;
      end
      RUN: begin
        busy = 1'b0;
        if (reload) begin
          state_next = LOAD;
          words_next = '0;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      cnt          <= '0;
      loaded_words <= '0;
      cpu_rst_n    <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      loaded_words <= words_next;
      // Registered so cpu_rst_n is high exactly while the state register is RUN.
      cpu_rst_n    <= (state_next == RUN);
    end
  end

  // NOTE: the storage array has no reset; loaded_words alone decides which
  // entries are visible, so stale contents never reach the CPU.
  always_ff @(posedge clk) begin
    if (accept) mem[loaded_words[AW-1:0]] <= load.load_data;
  end

  // Addresses below BASE_ADDR wrap to a huge index and fall through to NOP.
  assign off             = pc - BASE_ADDR;
  assign idx             = off[31:2];
  assign unused_off_lsbs = ^off[1:0];

  always_comb begin
    instruction = NOP_INSN;
    if (idx < 30'(loaded_words)) instruction = mem[idx[AW-1:0]];
  end

endmodule
